// File: rtl/bus_arb_mux.sv
// rtl/bus_arb_mux.sv - N:1 valid/ready multiplexer with round-robin or fixed-priority arbiter
// and a single registered output stage.
module bus_arb_mux #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 16,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [CHANNELS-1:0][WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]            in_valid,
  output logic [CHANNELS-1:0]            in_ready,
  input  logic                           fixed_prio,
  output logic [WIDTH-1:0]               out_data,
  output logic [SEL_W-1:0]               out_sel,
  output logic                           out_valid,
  input  logic                           out_ready
);

  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_win;
  logic [SEL_W-1:0] fp_win;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] next_ptr;
  logic [SEL_W:0]   cand;
  logic             any_valid;
  logic             load;

  assign any_valid = |in_valid;
  assign load      = !out_valid || out_ready;
  assign winner    = fixed_prio ? fp_win : rr_win;
  assign next_ptr  = (winner == SEL_W'(CHANNELS - 1)) ? '0 : winner + SEL_W'(1);

  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    fp_win = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i]) fp_win = SEL_W'(i);
    end
  end

  // Offsets from the pointer, wrapped modulo CHANNELS; smallest offset wins.
  always_comb begin
    rr_win = '0;
    cand   = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + (SEL_W + 1)'(k);
      if (cand >= (SEL_W + 1)'(CHANNELS)) cand = cand - (SEL_W + 1)'(CHANNELS);
      if (in_valid[cand[SEL_W-1:0]]) rr_win = cand[SEL_W-1:0];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = load && (winner == SEL_W'(i)) && in_valid[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      out_valid <= any_valid;
      if (any_valid) begin
        out_data <= in_data[winner];
        out_sel  <= winner;
        if (!fixed_prio) rr_ptr <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_bus_arb_mux.sv
// tb/tb_bus_arb_mux.sv - scoreboard bench for bus_arb_mux (4-channel directed, 5-channel random)
module tb_bus_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [3:0][7:0] a_in_data;
  logic [3:0]      a_in_valid, a_in_ready;
  logic            a_fixed, a_out_valid, a_out_ready;
  logic [7:0]      a_out_data;
  logic [1:0]      a_out_sel;

  logic [4:0][63:0] b_in_data;
  logic [4:0]       b_in_valid, b_in_ready;
  logic             b_fixed, b_out_valid, b_out_ready;
  logic [63:0]      b_out_data;
  logic [2:0]       b_out_sel;

  int checks = 0;
  int errors = 0;

  logic [9:0]  a_q[$];
  logic [66:0] b_q[$];

  bus_arb_mux #(.WIDTH(8), .CHANNELS(4)) dut_a (
    .clk(clk), .reset(reset), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .fixed_prio(a_fixed), .out_data(a_out_data),
    .out_sel(a_out_sel), .out_valid(a_out_valid), .out_ready(a_out_ready)
  );

  bus_arb_mux #(.WIDTH(64), .CHANNELS(5)) dut_b (
    .clk(clk), .reset(reset), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .fixed_prio(b_fixed), .out_data(b_out_data),
    .out_sel(b_out_sel), .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    a_in_valid = '0;
    b_in_valid = '0;
    tick();
    reset = 1'b0;
    a_q.delete();
    b_q.delete();
  endtask

  task automatic test_reset();
    logic [9:0] exp;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", a_out_valid); end
    checks++; if (a_out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", a_out_data); end
    checks++; if (a_out_sel !== 2'd0) begin errors++; $display("FAIL rst_sel got %0d exp 0", a_out_sel); end
    a_in_data[2] = 8'hA5;
    a_in_valid = 4'b0100;
    a_out_ready = 1'b0;
    #1;
    checks++; if (a_in_ready !== 4'b0100) begin errors++; $display("FAIL ms_ready got %b exp 0100", a_in_ready); end
    a_q.push_back({2'd2, 8'hA5});
    tick();
    exp = a_q[0];
    checks++; if (a_out_valid !== 1'b1 || {a_out_sel, a_out_data} !== exp) begin
      errors++; $display("FAIL ms_load got v%0b %0d/%h exp v1 %0d/%h", a_out_valid, a_out_sel, a_out_data, exp[9:8], exp[7:0]); end
    a_in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    a_in_valid = 4'b1111;
    #1;
    checks++; if (a_in_ready !== 4'b0000) begin errors++; $display("FAIL ms_stall_ready got %b exp 0000", a_in_ready); end
    tick();
    checks++; if ({a_out_sel, a_out_data} !== exp) begin errors++; $display("FAIL ms_hold got %0d/%h exp %0d/%h", a_out_sel, a_out_data, exp[9:8], exp[7:0]); end
    reset = 1'b1;
    a_in_valid = '0;
    tick();
    reset = 1'b0;
    a_q.delete();
    checks++; if (a_out_valid !== 1'b0 || a_out_data !== 8'h00 || a_out_sel !== 2'd0 || a_in_ready !== 4'b0000) begin
      errors++; $display("FAIL ms_after_rst got v%0b %0d/%h r%b exp v0 0/00 r0000", a_out_valid, a_out_sel, a_out_data, a_in_ready); end
    a_in_valid = 4'b1111;
    #1;
    checks++; if (a_in_ready !== 4'b0001) begin errors++; $display("FAIL ms_first_grant got %b exp 0001", a_in_ready); end
    a_out_ready = 1'b1;
    a_q.push_back({2'd0, 8'h10});
    tick();
    exp = a_q.pop_front();
    checks++; if (a_out_valid !== 1'b1 || {a_out_sel, a_out_data} !== exp) begin
      errors++; $display("FAIL ms_ch0 got %0d/%h exp %0d/%h", a_out_sel, a_out_data, exp[9:8], exp[7:0]); end
  endtask

  task automatic test_round_robin();
    logic [9:0] exp;
    logic [1:0] s;
    do_reset();
    a_fixed = 1'b0;
    a_out_ready = 1'b1;
    a_in_data = {8'h13, 8'h12, 8'h11, 8'h10};
    a_in_valid = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      s = 2'(i % 4);
      #1;
      checks++; if (a_in_ready !== (4'b0001 << s)) begin errors++; $display("FAIL rr_ready[%0d] got %b exp onehot %0d", i, a_in_ready, s); end
      a_q.push_back({s, 8'h10 + 8'(s)});
      tick();
      exp = a_q.pop_front();
      checks++; if (a_out_valid !== 1'b1 || {a_out_sel, a_out_data} !== exp) begin
        errors++; $display("FAIL rr_beat[%0d] got v%0b %0d/%h exp %0d/%h", i, a_out_valid, a_out_sel, a_out_data, exp[9:8], exp[7:0]); end
    end
  endtask

  task automatic test_fixed_prio();
    logic [9:0] exp;
    a_fixed = 1'b1;
    a_in_valid = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (a_in_ready !== 4'b0010) begin errors++; $display("FAIL fp_ready[%0d] got %b exp 0010", i, a_in_ready); end
      a_q.push_back({2'd1, 8'h11});
      tick();
      exp = a_q.pop_front();
      checks++; if ({a_out_sel, a_out_data} !== exp) begin errors++; $display("FAIL fp_beat[%0d] got %0d/%h exp 1/11", i, a_out_sel, a_out_data); end
    end
    a_fixed = 1'b0;
    #1;
    checks++; if (a_in_ready !== 4'b1000) begin errors++; $display("FAIL fp_resume_ready got %b exp 1000", a_in_ready); end
    a_q.push_back({2'd3, 8'h13});
    tick();
    exp = a_q.pop_front();
    checks++; if ({a_out_sel, a_out_data} !== exp) begin errors++; $display("FAIL fp_resume got %0d/%h exp 3/13", a_out_sel, a_out_data); end
  endtask

  task automatic test_backpressure();
    logic [9:0] exp;
    int xfers;
    do_reset();
    xfers = 0;
    a_in_data[1] = 8'h3C;
    a_in_valid = 4'b0010;
    a_out_ready = 1'b0;
    #1;
    checks++; if (a_in_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_ready got %b exp 0010", a_in_ready); end
    a_q.push_back({2'd1, 8'h3C});
    tick();
    exp = a_q.pop_front();
    checks++; if (a_out_valid !== 1'b1 || {a_out_sel, a_out_data} !== exp) begin
      errors++; $display("FAIL bp_load got v%0b %0d/%h exp v1 1/3c", a_out_valid, a_out_sel, a_out_data); end
    for (int i = 0; i < 5; i++) begin
      #1;
      if (a_in_ready != 4'b0000) xfers++;
      checks++; if (a_in_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d] got %b exp 0000", i, a_in_ready); end
      tick();
      checks++; if (a_out_valid !== 1'b1 || {a_out_sel, a_out_data} !== exp) begin
        errors++; $display("FAIL bp_stall_hold[%0d] got v%0b %0d/%h exp v1 1/3c", i, a_out_valid, a_out_sel, a_out_data); end
    end
    a_out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 4'b0010) begin errors++; $display("FAIL bp_pop_ready got %b exp 0010", a_in_ready); end
    checks++; if (xfers !== 0) begin errors++; $display("FAIL bp_extra_xfers got %0d exp 0", xfers); end
    a_q.push_back({2'd1, 8'h3C});
    tick();
    exp = a_q.pop_front();
    checks++; if (a_out_valid !== 1'b1 || {a_out_sel, a_out_data} !== exp) begin
      errors++; $display("FAIL bp_popush got v%0b %0d/%h exp v1 1/3c", a_out_valid, a_out_sel, a_out_data); end
    a_in_valid = 4'b0000;
    #1;
    checks++; if (a_in_ready !== 4'b0000) begin errors++; $display("FAIL bp_idle_ready got %b exp 0000", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b0 || {a_out_sel, a_out_data} !== exp) begin
      errors++; $display("FAIL bp_drain got v%0b %0d/%h exp v0 1/3c", a_out_valid, a_out_sel, a_out_data); end
  endtask

  task automatic test_sparse_wrap();
    logic [9:0] exp;
    do_reset();
    a_fixed = 1'b0;
    a_out_ready = 1'b1;
    a_in_data = {8'h13, 8'h12, 8'h11, 8'hE7};
    a_in_valid = 4'b0010;
    tick();
    a_in_valid = 4'b0001;
    #1;
    checks++; if (a_in_ready !== 4'b0001) begin errors++; $display("FAIL sw_ready got %b exp 0001", a_in_ready); end
    a_q.push_back({2'd0, 8'hE7});
    tick();
    exp = a_q.pop_front();
    checks++; if (a_out_valid !== 1'b1 || {a_out_sel, a_out_data} !== exp) begin
      errors++; $display("FAIL sw_beat got v%0b %0d/%h exp v1 0/e7", a_out_valid, a_out_sel, a_out_data); end
    a_in_valid = 4'b1111;
    #1;
    checks++; if (a_in_ready !== 4'b0010) begin errors++; $display("FAIL sw_ptr got %b exp 0010", a_in_ready); end
    a_in_valid = 4'b0000;
    #1;
    checks++; if (a_in_ready !== 4'b0000) begin errors++; $display("FAIL sw_none_ready got %b exp 0000", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b0 || {a_out_sel, a_out_data} !== exp) begin
      errors++; $display("FAIL sw_fall got v%0b %0d/%h exp v0 0/e7", a_out_valid, a_out_sel, a_out_data); end
  endtask

  task automatic test_random();
    int mptr;
    logic mvalid;
    logic mload;
    int win;
    int idx;
    int wait_cnt[5];
    logic [4:0] exp_ready;
    logic [66:0] exp;
    do_reset();
    b_fixed = 1'b0;
    mptr = 0;
    mvalid = 1'b0;
    for (int c = 0; c < 5; c++) wait_cnt[c] = 0;
    for (int n = 0; n < 10000; n++) begin
      for (int c = 0; c < 5; c++) begin
        if (!b_in_valid[c]) begin
          b_in_valid[c] = ($urandom_range(0, 99) < 40);
          b_in_data[c] = {$urandom, $urandom};
        end
      end
      b_out_ready = ($urandom_range(0, 99) < 70);
      #1;
      mload = !mvalid || b_out_ready;
      win = -1;
      if (mload) begin
        for (int k = 0; k < 5; k++) begin
          idx = (mptr + k) % 5;
          if (win < 0 && b_in_valid[idx]) win = idx;
        end
      end
      exp_ready = '0;
      if (win >= 0) exp_ready[win] = 1'b1;
      checks++; if (b_in_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, b_in_ready, exp_ready); end
      checks++; if (b_out_valid !== mvalid) begin errors++; $display("FAIL rnd_valid[%0d] got %0b exp %0b", n, b_out_valid, mvalid); end
      if (mvalid && b_out_ready) begin
        checks++;
        if (b_q.size() == 0) begin
          errors++; $display("FAIL rnd_pop_empty[%0d] got beat %0d/%h exp none", n, b_out_sel, b_out_data);
        end else begin
          exp = b_q.pop_front();
          if ({b_out_sel, b_out_data} !== exp) begin
            errors++; $display("FAIL rnd_beat[%0d] got %0d/%h exp %0d/%h", n, b_out_sel, b_out_data, exp[66:64], exp[63:0]); end
        end
        checks++; if (b_out_sel >= 3'd5) begin errors++; $display("FAIL rnd_sel_range[%0d] got %0d exp <5", n, b_out_sel); end
      end
      if (win >= 0) begin
        for (int c = 0; c < 5; c++) begin
          if (c == win) begin
            checks++; if (wait_cnt[c] >= 5) begin errors++; $display("FAIL rnd_starve ch%0d got %0d exp <5", c, wait_cnt[c]); end
            wait_cnt[c] = 0;
          end else if (b_in_valid[c]) begin
            wait_cnt[c]++;
          end
        end
        b_q.push_back({3'(win), b_in_data[win]});
        mptr = (win + 1) % 5;
        mvalid = 1'b1;
      end else if (mload) begin
        mvalid = 1'b0;
      end
      tick();
      if (win >= 0) b_in_valid[win] = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1;
    a_in_data = '0;
    a_in_valid = '0;
    a_fixed = 1'b0;
    a_out_ready = 1'b0;
    b_in_data = '0;
    b_in_valid = '0;
    b_fixed = 1'b0;
    b_out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_fixed_prio();
    test_backpressure();
    test_sparse_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
